// File: rtl/legv8_pkg.sv
// legv8_pkg
//   Shared definitions for the LEGv8 execute/memory pipeline slice.
//   - Bit positions of the ALU status / NZCV flag vector, ordered {V,C,N,Z}.
//   - Four-bit B.cond condition codes (EQ .. NV).
package legv8_pkg;

    // Bit indices into status[3:0] and flags[3:0]
    localparam int ST_V = 3;
    localparam int ST_C = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

    // B.cond condition codes
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/legv8_cond_eval.sv
// legv8_cond_eval
//   Combinational evaluation of a B.cond condition code against NZCV flags.
//   Ports:
//     flags [3:0] in  : architectural flags, {V,C,N,Z}
//     cond  [3:0] in  : condition code
//     pass        out : 1 when the condition holds
module legv8_cond_eval
    import legv8_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       pass
);

    logic v, c, n, z;

    assign v = flags[ST_V];
    assign c = flags[ST_C];
    assign n = flags[ST_N];
    assign z = flags[ST_Z];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_HS: pass = c;
            COND_LO: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            // AL and NV both mean "always" in LEGv8
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/legv8_ex_mem_stage.sv
// legv8_ex_mem_stage
//   EX/MEM pipeline register sitting directly after the 64-bit LEGv8 ALU.
//   Holds the architectural NZCV flags and resolves B.cond / CBZ / CBNZ into
//   a registered take-branch bit for fetch.
//   Ports:
//     clock, reset_n            : rising-edge clock, async active-low reset
//     in_valid / in_ready       : upstream handshake from EX
//     F, status                 : ALU result and ALU flags {V,C,N,Z}
//     store_data, branch_target : STUR data, computed branch address
//     rd, reg_write, mem_read, mem_write, set_flags : control fields
//     is_bcond, is_cbz, is_cbnz, cond : branch kind and condition code
//     flush                     : kill held entry and inbound instruction
//     out_valid / out_ready     : downstream handshake to MEM
//     out_*                     : registered payload
//     flags                     : architectural NZCV, {V,C,N,Z}
module legv8_ex_mem_stage
    import legv8_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] F,
    input  logic [3:0]       status,
    input  logic [WIDTH-1:0] store_data,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [4:0]       rd,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             set_flags,
    input  logic             is_bcond,
    input  logic             is_cbz,
    input  logic             is_cbnz,
    input  logic [3:0]       cond,
    input  logic             flush,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_store_data,
    output logic [WIDTH-1:0] out_branch_target,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_take_branch,
    output logic [3:0]       flags
);

    // Handshake: a side transfers on a cycle where its valid and ready are
    // both high at the rising edge. valid must not depend on ready; the
    // register may accept and drain in the same cycle, so in_ready is high
    // whenever the register is empty or is being emptied this cycle. flush
    // overrides everything: nothing is accepted and the held entry is killed.
    logic accept;
    logic cond_pass;
    logic take_branch_d;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    // B.cond looks at the flags register as it stands now, i.e. before any
    // update made by this same accept; that is what gives a flag-setting
    // instruction in cycle n visibility to a B.cond accepted in cycle n+1.
    legv8_cond_eval u_cond_eval (
        .flags (flags),
        .cond  (cond),
        .pass  (cond_pass)
    );

    // CBZ/CBNZ test the zero flag of the ALU result that accompanies them.
    // Priority bcond > cbz > cbnz only matters for illegal encodings.
    always_comb begin
        take_branch_d = 1'b0;
        if (is_bcond) begin
            take_branch_d = cond_pass;
        end else if (is_cbz) begin
            take_branch_d = status[ST_Z];
        end else if (is_cbnz) begin
            take_branch_d = ~status[ST_Z];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid         <= 1'b0;
            out_result        <= '0;
            out_store_data    <= '0;
            out_branch_target <= '0;
            out_rd            <= '0;
            out_reg_write     <= 1'b0;
            out_mem_read      <= 1'b0;
            out_mem_write     <= 1'b0;
            out_take_branch   <= 1'b0;
            flags             <= 4'b0000;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid         <= 1'b1;
            out_result        <= F;
            out_store_data    <= store_data;
            out_branch_target <= branch_target;
            out_rd            <= rd;
            out_reg_write     <= reg_write;
            out_mem_read      <= mem_read;
            out_mem_write     <= mem_write;
            out_take_branch   <= take_branch_d;
            if (set_flags) begin
                flags <= status;
            end
        end else if (out_ready) begin
            // Drain with no replacement; payload keeps its last value.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_legv8_ex_mem_stage.sv
module tb_legv8_ex_mem_stage;

  localparam int W = 64;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] f;
  logic [3:0]   status;
  logic [W-1:0] store_data;
  logic [W-1:0] branch_target;
  logic [4:0]   rd;
  logic         reg_write, mem_read, mem_write, set_flags;
  logic         is_bcond, is_cbz, is_cbnz;
  logic [3:0]   cond;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result, out_store_data, out_branch_target;
  logic [4:0]   out_rd;
  logic         out_reg_write, out_mem_read, out_mem_write, out_take_branch;
  logic [3:0]   flags;

  int tests_run;
  int tests_failed;

  legv8_ex_mem_stage #(.WIDTH(W)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .F                 (f),
    .status            (status),
    .store_data        (store_data),
    .branch_target     (branch_target),
    .rd                (rd),
    .reg_write         (reg_write),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .set_flags         (set_flags),
    .is_bcond          (is_bcond),
    .is_cbz            (is_cbz),
    .is_cbnz           (is_cbnz),
    .cond              (cond),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_result        (out_result),
    .out_store_data    (out_store_data),
    .out_branch_target (out_branch_target),
    .out_rd            (out_rd),
    .out_reg_write     (out_reg_write),
    .out_mem_read      (out_mem_read),
    .out_mem_write     (out_mem_write),
    .out_take_branch   (out_take_branch),
    .flags             (flags)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- vector table ----------------
  typedef struct {
    logic         iv;
    logic [W-1:0] f;
    logic [3:0]   st;
    logic         sf;
    logic [4:0]   rd;
    logic [2:0]   ctl;   // {reg_write, mem_read, mem_write}
    logic [2:0]   br;    // {is_bcond, is_cbz, is_cbnz}
    logic [3:0]   cnd;
    logic         e_valid;
    logic [W-1:0] e_result;
    logic [4:0]   e_rd;
    logic         e_take;
    logic [3:0]   e_flags;
    logic [2:0]   e_ctl;
  } vec_t;

  vec_t vec_q[$];

  // scoreboard for payload fields that simply follow the last accept
  logic [W-1:0] exp_q[$];

  task automatic add_vec(input logic iv, input logic [W-1:0] fv, input logic [3:0] st,
                         input logic sf, input logic [4:0] rdv, input logic [2:0] ctl,
                         input logic [2:0] br, input logic [3:0] cnd,
                         input logic ev, input logic [W-1:0] er, input logic [4:0] erd,
                         input logic et, input logic [3:0] ef, input logic [2:0] ec);
    vec_t v;
    v.iv = iv; v.f = fv; v.st = st; v.sf = sf; v.rd = rdv; v.ctl = ctl;
    v.br = br; v.cnd = cnd; v.e_valid = ev; v.e_result = er; v.e_rd = erd;
    v.e_take = et; v.e_flags = ef; v.e_ctl = ec;
    vec_q.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid = 1'b0; f = '0; status = '0; store_data = '0; branch_target = '0;
    rd = '0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; set_flags = 1'b0;
    is_bcond = 1'b0; is_cbz = 1'b0; is_cbnz = 1'b0; cond = '0; flush = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic drive_instr(input logic [W-1:0] fv, input logic [3:0] st, input logic sf,
                             input logic [4:0] rdv);
    in_valid = 1'b1; f = fv; status = st; set_flags = sf; rd = rdv;
    reg_write = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    is_bcond = 1'b0; is_cbz = 1'b0; is_cbnz = 1'b0; cond = '0;
    store_data = fv ^ 64'h5555; branch_target = fv ^ 64'hAAAA;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    tests_run = 0;
    tests_failed = 0;
    idle_inputs();
    reset_n = 1'b0;

    // directed table: each row is one cycle with out_ready=1, no flush
    //       iv    F          status   sf    rd     ctl     br      cond   ev    result     rd     take  flags    ctl
    add_vec(1'b1, 64'h3,     4'b0000, 1'b0, 5'd5,  3'b100, 3'b000, 4'h0, 1'b1, 64'h3,     5'd5,  1'b0, 4'b0000, 3'b100); // 0 plain ADD
    add_vec(1'b1, 64'h0,     4'b0001, 1'b1, 5'd1,  3'b100, 3'b000, 4'h0, 1'b1, 64'h0,     5'd1,  1'b0, 4'b0001, 3'b100); // 1 SUBS -> Z
    add_vec(1'b1, 64'h102,   4'b0000, 1'b0, 5'd2,  3'b000, 3'b100, 4'h0, 1'b1, 64'h102,   5'd2,  1'b1, 4'b0001, 3'b000); // 2 B.EQ
    add_vec(1'b1, 64'h103,   4'b0000, 1'b0, 5'd3,  3'b000, 3'b100, 4'h1, 1'b1, 64'h103,   5'd3,  1'b0, 4'b0001, 3'b000); // 3 B.NE
    add_vec(1'b1, 64'h104,   4'b0001, 1'b0, 5'd4,  3'b000, 3'b010, 4'h0, 1'b1, 64'h104,   5'd4,  1'b1, 4'b0001, 3'b000); // 4 CBZ
    add_vec(1'b1, 64'h105,   4'b0001, 1'b0, 5'd5,  3'b000, 3'b001, 4'h0, 1'b1, 64'h105,   5'd5,  1'b0, 4'b0001, 3'b000); // 5 CBNZ
    add_vec(1'b1, 64'h106,   4'b1010, 1'b1, 5'd6,  3'b100, 3'b000, 4'h0, 1'b1, 64'h106,   5'd6,  1'b0, 4'b1010, 3'b100); // 6 ADDS V,N
    add_vec(1'b1, 64'h107,   4'b0000, 1'b0, 5'd7,  3'b000, 3'b100, 4'hA, 1'b1, 64'h107,   5'd7,  1'b1, 4'b1010, 3'b000); // 7 GE
    add_vec(1'b1, 64'h108,   4'b0000, 1'b0, 5'd8,  3'b000, 3'b100, 4'hB, 1'b1, 64'h108,   5'd8,  1'b0, 4'b1010, 3'b000); // 8 LT
    add_vec(1'b1, 64'h109,   4'b0000, 1'b0, 5'd9,  3'b000, 3'b100, 4'h8, 1'b1, 64'h109,   5'd9,  1'b0, 4'b1010, 3'b000); // 9 HI (C=0)
    add_vec(1'b1, 64'h10A,   4'b0100, 1'b1, 5'd10, 3'b110, 3'b000, 4'h0, 1'b1, 64'h10A,   5'd10, 1'b0, 4'b0100, 3'b110); // 10 flags C
    add_vec(1'b1, 64'h10B,   4'b0000, 1'b0, 5'd11, 3'b000, 3'b100, 4'h8, 1'b1, 64'h10B,   5'd11, 1'b1, 4'b0100, 3'b000); // 11 HI
    add_vec(1'b1, 64'h10C,   4'b0000, 1'b0, 5'd12, 3'b000, 3'b100, 4'h9, 1'b1, 64'h10C,   5'd12, 1'b0, 4'b0100, 3'b000); // 12 LS
    add_vec(1'b1, 64'h10D,   4'b0000, 1'b0, 5'd13, 3'b000, 3'b100, 4'hC, 1'b1, 64'h10D,   5'd13, 1'b1, 4'b0100, 3'b000); // 13 GT
    add_vec(1'b1, 64'h10E,   4'b0000, 1'b0, 5'd14, 3'b000, 3'b100, 4'hD, 1'b1, 64'h10E,   5'd14, 1'b0, 4'b0100, 3'b000); // 14 LE
    add_vec(1'b1, 64'h10F,   4'b0000, 1'b0, 5'd15, 3'b000, 3'b110, 4'hE, 1'b1, 64'h10F,   5'd15, 1'b1, 4'b0100, 3'b000); // 15 AL beats CBZ
    add_vec(1'b1, 64'h110,   4'b0000, 1'b0, 5'd16, 3'b000, 3'b100, 4'hF, 1'b1, 64'h110,   5'd16, 1'b1, 4'b0100, 3'b000); // 16 NV
    add_vec(1'b1, 64'h111,   4'b0000, 1'b0, 5'd17, 3'b000, 3'b100, 4'h4, 1'b1, 64'h111,   5'd17, 1'b0, 4'b0100, 3'b000); // 17 MI
    add_vec(1'b1, 64'h112,   4'b0000, 1'b0, 5'd18, 3'b001, 3'b000, 4'h0, 1'b1, 64'h112,   5'd18, 1'b0, 4'b0100, 3'b001); // 18 STUR
    add_vec(1'b0, 64'h999,   4'b1111, 1'b1, 5'd19, 3'b100, 3'b100, 4'hE, 1'b0, 64'h112,   5'd18, 1'b0, 4'b0100, 3'b001); // 19 bubble
    add_vec(1'b1, 64'h114,   4'b1001, 1'b1, 5'd20, 3'b100, 3'b001, 4'h0, 1'b1, 64'h114,   5'd20, 1'b0, 4'b1001, 3'b100); // 20 SUBS+CBNZ
    add_vec(1'b1, 64'h115,   4'b0000, 1'b0, 5'd21, 3'b000, 3'b100, 4'h6, 1'b1, 64'h115,   5'd21, 1'b1, 4'b1001, 3'b000); // 21 VS
    add_vec(1'b1, 64'h116,   4'b0000, 1'b0, 5'd22, 3'b000, 3'b100, 4'h7, 1'b1, 64'h116,   5'd22, 1'b0, 4'b1001, 3'b000); // 22 VC
    add_vec(1'b1, 64'h117,   4'b0000, 1'b0, 5'd23, 3'b000, 3'b100, 4'h0, 1'b1, 64'h117,   5'd23, 1'b1, 4'b1001, 3'b000); // 23 EQ
    add_vec(1'b1, 64'h118,   4'b0000, 1'b0, 5'd24, 3'b000, 3'b100, 4'h2, 1'b1, 64'h118,   5'd24, 1'b0, 4'b1001, 3'b000); // 24 HS
    add_vec(1'b1, 64'h119,   4'b0000, 1'b0, 5'd25, 3'b000, 3'b100, 4'h3, 1'b1, 64'h119,   5'd25, 1'b1, 4'b1001, 3'b000); // 25 LO
    add_vec(1'b1, 64'h11A,   4'b0000, 1'b0, 5'd26, 3'b000, 3'b100, 4'h5, 1'b1, 64'h11A,   5'd26, 1'b1, 4'b1001, 3'b000); // 26 PL
    add_vec(1'b1, 64'h11B,   4'b0000, 1'b1, 5'd27, 3'b000, 3'b100, 4'h0, 1'b1, 64'h11B,   5'd27, 1'b1, 4'b0000, 3'b000); // 27 EQ uses old flags
    add_vec(1'b1, 64'h11C,   4'b0000, 1'b0, 5'd28, 3'b000, 3'b100, 4'h0, 1'b1, 64'h11C,   5'd28, 1'b0, 4'b0000, 3'b000); // 28 EQ after clear

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset out_valid", {63'b0, out_valid}, 64'd0);
    check("reset flags", {60'b0, flags}, 64'd0);
    check("reset in_ready", {63'b0, in_ready}, 64'd1);
    check("reset out_result", out_result, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // table loop
    for (int i = 0; i < vec_q.size(); i++) begin
      @(negedge clock);
      in_valid      = vec_q[i].iv;
      f             = vec_q[i].f;
      status        = vec_q[i].st;
      set_flags     = vec_q[i].sf;
      rd            = vec_q[i].rd;
      {reg_write, mem_read, mem_write} = vec_q[i].ctl;
      {is_bcond, is_cbz, is_cbnz}      = vec_q[i].br;
      cond          = vec_q[i].cnd;
      store_data    = 64'h5000 + 64'(i);
      branch_target = 64'h8000 + 64'(i);
      flush         = 1'b0;
      out_ready     = 1'b1;
      if (vec_q[i].iv) begin
        exp_q.delete();
        exp_q.push_back(64'h5000 + 64'(i));
        exp_q.push_back(64'h8000 + 64'(i));
      end
      @(posedge clock);
      #1;
      check($sformatf("v%0d out_valid", i), {63'b0, out_valid}, {63'b0, vec_q[i].e_valid});
      check($sformatf("v%0d out_result", i), out_result, vec_q[i].e_result);
      check($sformatf("v%0d out_rd", i), {59'b0, out_rd}, {59'b0, vec_q[i].e_rd});
      check($sformatf("v%0d flags", i), {60'b0, flags}, {60'b0, vec_q[i].e_flags});
      check($sformatf("v%0d ctl", i), {61'b0, out_reg_write, out_mem_read, out_mem_write},
            {61'b0, vec_q[i].e_ctl});
      if (vec_q[i].e_valid)
        check($sformatf("v%0d take", i), {63'b0, out_take_branch}, {63'b0, vec_q[i].e_take});
      if (exp_q.size() == 2) begin
        check($sformatf("v%0d store_data", i), out_store_data, exp_q[0]);
        check($sformatf("v%0d branch_target", i), out_branch_target, exp_q[1]);
      end
    end

    // backpressure: row 28 is held while a flag-setting instruction waits
    @(negedge clock);
    drive_instr(64'hAAAA, 4'b1111, 1'b1, 5'd7);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("bp%0d in_ready", k), {63'b0, in_ready}, 64'd0);
      check($sformatf("bp%0d out_valid", k), {63'b0, out_valid}, 64'd1);
      check($sformatf("bp%0d out_result", k), out_result, 64'h11C);
      check($sformatf("bp%0d out_rd", k), {59'b0, out_rd}, 64'd28);
      check($sformatf("bp%0d flags", k), {60'b0, flags}, 64'd0);
    end
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    check("release in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clock);
    #1;
    check("drain+accept out_valid", {63'b0, out_valid}, 64'd1);
    check("drain+accept out_result", out_result, 64'hAAAA);
    check("drain+accept out_rd", {59'b0, out_rd}, 64'd7);
    check("drain+accept flags", {60'b0, flags}, 64'hF);

    // flush while stalled with a flag-setting instruction inbound
    @(negedge clock);
    drive_instr(64'hBBBB, 4'b0101, 1'b1, 5'd8);
    out_ready = 1'b0;
    flush = 1'b1;
    @(posedge clock);
    #1;
    check("flush out_valid", {63'b0, out_valid}, 64'd0);
    check("flush flags", {60'b0, flags}, 64'hF);
    check("flush out_result held", out_result, 64'hAAAA);
    check("flush in_ready", {63'b0, in_ready}, 64'd1);

    // refill after flush
    @(negedge clock);
    flush = 1'b0;
    drive_instr(64'hCCCC, 4'b0000, 1'b0, 5'd9);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check("refill out_valid", {63'b0, out_valid}, 64'd1);
    check("refill out_result", out_result, 64'hCCCC);
    check("refill flags", {60'b0, flags}, 64'hF);

    // asynchronous reset between edges, instruction still in flight
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst out_valid", {63'b0, out_valid}, 64'd0);
    check("async rst flags", {60'b0, flags}, 64'd0);
    check("async rst out_result", out_result, 64'd0);
    check("async rst in_ready", {63'b0, in_ready}, 64'd1);
    idle_inputs();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("post rst out_valid", {63'b0, out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
